// File: rtl/seg7_pkg.sv
// Shared types, blank pattern and hex-to-segment table for the seven-segment scan driver.
// Optional blinking in the driver is enabled with SEG7_BLINK_EN.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;

  // Active-low segments, bit0 = a .. bit6 = g; lower-case b and d keep them distinct from 8 and 0.
  function automatic seg7_t hex_to_seg7(input logic [3:0] nibble);
    seg7_t seg;
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Valid/ready load port carrying a packed hex value into the scan driver's shadow register.
// The driver side is the slave; user/control logic is the master.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);

  logic [4*DIGITS-1:0] VALUE_IN;
  logic                LOAD_VALID;
  logic                LOAD_READY;

  modport master (output VALUE_IN, output LOAD_VALID, input LOAD_READY);
  modport slave  (input VALUE_IN, input LOAD_VALID, output LOAD_READY);

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit to active-low 7-segment decoder used on the currently scanned nibble.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg7_t      seg_o
);

  assign seg_o = hex_to_seg7(nibble_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit multiplexed hex display driver with double-buffered load and leading-zero blanking.
// Define SEG7_BLINK_EN to add the BLINK_MASK port and the per-digit blink logic.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  seg7_scan_driver_if.slave load_if,
  input  logic              BLANK_LZ,
`ifdef SEG7_BLINK_EN
  input  logic [DIGITS-1:0] BLINK_MASK,
`endif
  output logic [6:0]        SEG_N,
  output logic [DIGITS-1:0] DIG_N,
  output logic              FRAME_TICK
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS);

  if (DIGITS < 2 || DIGITS > 8 || SCAN_DIV < 2 || BLINK_FRAMES < 1) begin : g_paramCheck
    $error("seg7_scan_driver: parameter out of range");
  end

  logic [PRE_W-1:0]    prescale_q, prescale_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, active_q;
  logic                pending_q;
  seg7_t               segN_q;
  logic [DIGITS-1:0]   digN_q;

  logic                termCount, frameEnd, loadFire;
  logic [3:0]          curNibble;
  logic                curBlank, curHide, allZero;
  logic [DIGITS-1:0]   digStrobe;
  seg7_t               curSeg;

  assign termCount = (prescale_q == PRE_W'(SCAN_DIV - 1));
  assign frameEnd  = termCount && (idx_q == IDX_W'(DIGITS - 1));
  assign loadFire  = load_if.LOAD_VALID && !pending_q;

  always_comb begin
    prescale_d = termCount ? '0 : prescale_q + 1'b1;
    idx_d      = idx_q;
    if (termCount) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BLK_W-1:0] blinkCnt_q;
  logic             blinkOn_q;

  // Phase flips once every BLINK_FRAMES frame boundaries so blinking stays locked to the scan.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      blinkCnt_q <= '0;
      blinkOn_q  <= 1'b1;
    end else if (frameEnd) begin
      if (blinkCnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
        blinkCnt_q <= '0;
        blinkOn_q  <= !blinkOn_q;
      end else begin
        blinkCnt_q <= blinkCnt_q + 1'b1;
      end
    end
  end
`endif

  // A digit above 0 is a leading zero when it and every more significant digit are zero.
  always_comb begin
    curNibble = '0;
    curBlank  = 1'b0;
    curHide   = 1'b0;
    digStrobe = '1;
    allZero   = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        curNibble    = active_q[4*k +: 4];
        digStrobe[k] = 1'b0;
        allZero      = 1'b1;
        for (int j = k; j < DIGITS; j++) begin
          if (active_q[4*j +: 4] != 4'h0) allZero = 1'b0;
        end
        curBlank = BLANK_LZ && (k > 0) && allZero;
`ifdef SEG7_BLINK_EN
        curHide  = !blinkOn_q && BLINK_MASK[k];
`endif
      end
    end
  end

  seg7_hex_decode u_hexDecode (
    .nibble_i (curNibble),
    .seg_o    (curSeg)
  );

  // Active only changes on a frame boundary, so a frame never mixes old and new digits.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      prescale_q <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      active_q   <= '0;
      pending_q  <= 1'b0;
      segN_q     <= SEG_BLANK;
      digN_q     <= '1;
    end else begin
      prescale_q <= prescale_d;
      idx_q      <= idx_d;
      if (loadFire) begin
        shadow_q  <= load_if.VALUE_IN;
        pending_q <= 1'b1;
      end else if (frameEnd && pending_q) begin
        active_q  <= shadow_q;
        pending_q <= 1'b0;
      end
      segN_q <= (curBlank || curHide) ? SEG_BLANK : curSeg;
      digN_q <= digStrobe;
    end
  end

  assign load_if.LOAD_READY = !pending_q;
  assign SEG_N              = segN_q;
  assign DIG_N              = digN_q;
  assign FRAME_TICK         = frameEnd;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed testbench for seg7_scan_driver with DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
// Blink checks are compiled in only when SEG7_BLINK_EN is defined.
module tb_seg7_scan_driver;

  localparam int DIGITS = 4;

  logic              clk;
  logic              reset;
  logic              blankLz;
  logic [6:0]        segN;
  logic [DIGITS-1:0] digN;
  logic              frameTick;
`ifdef SEG7_BLINK_EN
  logic [DIGITS-1:0] blinkMask;
`endif

  int checkCount = 0;
  int passCount  = 0;

  seg7_scan_driver_if #(.DIGITS(DIGITS)) loadIf ();

  seg7_scan_driver #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .CLOCK_50   (clk),
    .RESET      (reset),
    .load_if    (loadIf),
    .BLANK_LZ   (blankLz),
`ifdef SEG7_BLINK_EN
    .BLINK_MASK (blinkMask),
`endif
    .SEG_N      (segN),
    .DIG_N      (digN),
    .FRAME_TICK (frameTick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge; returns at the negedge after the offer was accepted.
  task automatic applyStimulus(input logic [15:0] value);
    int n = 0;
    while (!loadIf.LOAD_READY && n < 100) begin
      @(negedge clk);
      n++;
    end
    loadIf.VALUE_IN   = value;
    loadIf.LOAD_VALID = 1'b1;
    @(posedge clk);
    @(negedge clk);
    loadIf.LOAD_VALID = 1'b0;
  endtask

  task automatic waitFrameTick(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frameTick && n < 64);
    checkOutput(tag, {31'd0, frameTick}, 32'd1);
  endtask

  task automatic checkDigit(input string tag, input int k, input logic [6:0] expSeg);
    logic [DIGITS-1:0] expDig;
    int n = 0;
    expDig = ~(DIGITS'(1) << k);
    while (digN !== expDig && n < 64) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_strobe"}, {28'd0, digN}, {28'd0, expDig});
    checkOutput(tag, {25'd0, segN}, {25'd0, expSeg});
  endtask

  task automatic pulseReset(input string tag);
    reset = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_seg"},   {25'd0, segN},                 32'h7F);
    checkOutput({tag, "_dig"},   {28'd0, digN},                 32'hF);
    checkOutput({tag, "_ready"}, {31'd0, loadIf.LOAD_READY},    32'd1);
    checkOutput({tag, "_tick"},  {31'd0, frameTick},            32'd0);
    reset = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    blankLz           = 1'b0;
    loadIf.VALUE_IN   = '0;
    loadIf.LOAD_VALID = 1'b0;
`ifdef SEG7_BLINK_EN
    blinkMask         = '0;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_seg",   {25'd0, segN},              32'h7F);
    checkOutput("rst_dig",   {28'd0, digN},              32'hF);
    checkOutput("rst_ready", {31'd0, loadIf.LOAD_READY}, 32'd1);
    checkOutput("rst_tick",  {31'd0, frameTick},         32'd0);
    reset = 1'b0;

    applyStimulus(16'h1234);
    checkOutput("ready_after_load", {31'd0, loadIf.LOAD_READY}, 32'd0);
    waitFrameTick("tick_1234");
    @(negedge clk);
    checkOutput("ready_after_xfer", {31'd0, loadIf.LOAD_READY}, 32'd1);
    checkDigit("v1234_d0", 0, 7'h19);
    checkDigit("v1234_d1", 1, 7'h30);
    checkDigit("v1234_d2", 2, 7'h24);
    checkDigit("v1234_d3", 3, 7'h79);

    applyStimulus(16'hABCF);
    waitFrameTick("tick_abcf");
    checkDigit("vabcf_d0", 0, 7'h0E);
    checkDigit("vabcf_d1", 1, 7'h46);
    checkDigit("vabcf_d2", 2, 7'h03);
    checkDigit("vabcf_d3", 3, 7'h08);

    applyStimulus(16'hDE96);
    waitFrameTick("tick_de96");
    checkDigit("vde96_d0", 0, 7'h02);
    checkDigit("vde96_d1", 1, 7'h10);
    checkDigit("vde96_d2", 2, 7'h06);
    checkDigit("vde96_d3", 3, 7'h21);

    blankLz = 1'b1;
    applyStimulus(16'h0007);
    waitFrameTick("tick_0007");
    checkDigit("lz0007_d0", 0, 7'h78);
    checkDigit("lz0007_d1", 1, 7'h7F);
    checkDigit("lz0007_d2", 2, 7'h7F);
    checkDigit("lz0007_d3", 3, 7'h7F);

    applyStimulus(16'h0000);
    waitFrameTick("tick_0000");
    checkDigit("lz0000_d0", 0, 7'h40);
    checkDigit("lz0000_d1", 1, 7'h7F);
    checkDigit("lz0000_d3", 3, 7'h7F);

    applyStimulus(16'h0305);
    waitFrameTick("tick_0305");
    checkDigit("lz0305_d0", 0, 7'h12);
    checkDigit("lz0305_d1", 1, 7'h40);
    checkDigit("lz0305_d2", 2, 7'h30);
    checkDigit("lz0305_d3", 3, 7'h7F);
    blankLz = 1'b0;

    // Offer held across a boundary while pending: refused there, accepted the cycle after.
    applyStimulus(16'h1111);
    loadIf.VALUE_IN   = 16'h2222;
    loadIf.LOAD_VALID = 1'b1;
    waitFrameTick("tick_1111");
    checkOutput("ready_at_boundary", {31'd0, loadIf.LOAD_READY}, 32'd0);
    @(negedge clk);
    checkOutput("ready_post_boundary", {31'd0, loadIf.LOAD_READY}, 32'd1);
    @(negedge clk);
    loadIf.LOAD_VALID = 1'b0;
    checkOutput("held_accepted", {31'd0, loadIf.LOAD_READY}, 32'd0);
    checkOutput("no_tear_dig",   {28'd0, digN},              32'hE);
    checkOutput("no_tear_seg",   {25'd0, segN},              32'h79);
    waitFrameTick("tick_2222");
    checkDigit("v2222_d0", 0, 7'h24);
    checkDigit("v2222_d1", 1, 7'h24);

    applyStimulus(16'h5555);
    pulseReset("midrst");
    waitFrameTick("tick_post_rst_a");
    waitFrameTick("tick_post_rst_b");
    checkOutput("post_rst_ready", {31'd0, loadIf.LOAD_READY}, 32'd1);
    checkDigit("post_rst_d0", 0, 7'h40);
    checkDigit("post_rst_d2", 2, 7'h40);

`ifdef SEG7_BLINK_EN
    blinkMask = 4'b0001;
    pulseReset("blinkrst");
    applyStimulus(16'h8888);
    waitFrameTick("blink_b1");
    checkDigit("blink_on_d0", 0, 7'h00);
    checkDigit("blink_on_d1", 1, 7'h00);
    waitFrameTick("blink_b2");
    checkDigit("blink_off_d0", 0, 7'h7F);
    checkDigit("blink_off_d3", 3, 7'h00);
    waitFrameTick("blink_b3");
    checkDigit("blink_off2_d0", 0, 7'h7F);
    waitFrameTick("blink_b4");
    checkDigit("blink_on2_d0", 0, 7'h00);
    checkDigit("blink_on2_d2", 2, 7'h00);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
